// File: rtl/haz_pkg.sv
// Shared types for the hazard/stall controller: FSM state encoding and the
// load-tracker slot record. Slot addresses are zero-extended to HAZ_AW_MAX bits.
package haz_pkg;

   localparam int HAZ_AW_MAX = 8;

   typedef enum logic [1:0] {
      HAZ_IDLE     = 2'd0,
      HAZ_LU_STALL = 2'd1,
      HAZ_MD_WAIT  = 2'd2
   } haz_state_e;

   typedef struct packed {
      logic                  valid;
      logic [HAZ_AW_MAX-1:0] addr;
   } haz_slot_t;

   // A slot matches only a valid load to the same non-zero register.
   function automatic logic slot_match(input haz_slot_t s, input logic [HAZ_AW_MAX-1:0] a);
      return s.valid && (s.addr == a) && (a != {HAZ_AW_MAX{1'b0}});
   endfunction

endpackage

// File: rtl/haz_load_tracker.sv
// Tracks in-flight loads: slot 0 is the load currently in EX, slots 1..LOAD_LAT-1
// are that load aged by one cycle each (unconditional shift).
module haz_load_tracker
   import haz_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int REG_AW   = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_ex_valid,
   input  logic                   i_ex_mem_read,
   input  logic [REG_AW-1:0]      i_ex_w_addr,
   output haz_slot_t [LOAD_LAT-1:0] o_slots
);

   haz_slot_t w_slot0;

   // Current EX load; a load to x0 can never create a dependency.
   always_comb begin
      w_slot0.valid = i_ex_valid & i_ex_mem_read & (i_ex_w_addr != {REG_AW{1'b0}});
      w_slot0.addr  = HAZ_AW_MAX'(i_ex_w_addr);
   end

   assign o_slots[0] = w_slot0;

   generate
      if (LOAD_LAT > 1) begin : g_pipe
         haz_slot_t [LOAD_LAT-1:1] r_slots;

         // Age shift register for loads still waiting on data.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_slots <= {($bits(r_slots)){1'b0}};
            end else begin
               r_slots[1] <= w_slot0;
               for (int k = 2; k < LOAD_LAT; k++) begin
                  r_slots[k] <= r_slots[k-1];
               end
            end
         end

         assign o_slots[LOAD_LAT-1:1] = r_slots;
      end
   endgenerate

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, mul/div wait, flush bubbles.
// Optional stall-cycle counter enabled by macro HAZ_STALL_PERF_CNT_EN.
module hazard_stall_ctrl
   import haz_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] i_id_rs_addr,
   input  logic [NUM_SRC-1:0]        i_id_rs_use,
   input  logic                      i_id_md_start,
   input  logic                      i_ex_valid,
   input  logic                      i_ex_mem_read,
   input  logic [REG_AW-1:0]         i_ex_w_addr,
   input  logic                      i_md_done,
   input  logic                      i_flush,
   output logic                      o_pc_stall,
   output logic                      o_ifid_stall,
   output logic                      o_idex_bubble,
   output logic [1:0]                o_haz_state
`ifdef HAZ_STALL_PERF_CNT_EN
   ,output logic [31:0]              o_stall_cnt
`endif
);

   localparam logic [1:0] ST_IDLE = HAZ_IDLE;
   localparam logic [1:0] ST_LU   = HAZ_LU_STALL;
   localparam logic [1:0] ST_MD   = HAZ_MD_WAIT;

   haz_slot_t [LOAD_LAT-1:0] w_slots;
   logic       w_hit;
   logic       w_hit_early;
   logic       w_stall;
   logic       w_bubble;
   logic [1:0] w_next;
   logic [1:0] r_state;

   haz_load_tracker #(
      .LOAD_LAT (LOAD_LAT),
      .REG_AW   (REG_AW)
   ) u_tracker (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ex_valid    (i_ex_valid),
      .i_ex_mem_read (i_ex_mem_read),
      .i_ex_w_addr   (i_ex_w_addr),
      .o_slots       (w_slots)
   );

   // Load-use detection; an "early" hit comes from a slot that will still be tracked next cycle.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_early = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int s = 0; s < LOAD_LAT; s++) begin
            if (i_id_valid && i_id_rs_use[i] &&
                slot_match(w_slots[s], HAZ_AW_MAX'(i_id_rs_addr[i*REG_AW +: REG_AW]))) begin
               w_hit       = 1'b1;
               w_hit_early = w_hit_early | (s < LOAD_LAT-1);
            end else begin
               w_hit       = w_hit;
               w_hit_early = w_hit_early;
            end
         end
      end
   end

   // Next state and stall outputs; MD_WAIT outranks flush, flush outranks load-use.
   always_comb begin
      w_next   = r_state;
      w_stall  = 1'b0;
      w_bubble = 1'b0;
      case (r_state)
         ST_MD: begin
            if (i_md_done) begin
               w_next = ST_IDLE;
            end else begin
               w_stall  = 1'b1;
               w_bubble = 1'b1;
            end
         end
         ST_IDLE, ST_LU: begin
            if (i_flush) begin
               w_bubble = 1'b1;
               w_next   = ST_IDLE;
            end else if (w_hit) begin
               w_stall  = 1'b1;
               w_bubble = 1'b1;
               w_next   = ((LOAD_LAT > 1) && ((r_state == ST_IDLE) || w_hit_early)) ? ST_LU : ST_IDLE;
            end else if ((r_state == ST_IDLE) && i_id_valid && i_id_md_start) begin
               w_next = ST_MD;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Outputs are combinational, so they are gated while reset is held.
   assign o_pc_stall    = i_rst_n & w_stall;
   assign o_ifid_stall  = i_rst_n & w_stall;
   assign o_idex_bubble = i_rst_n & w_bubble;
   assign o_haz_state   = r_state;

`ifdef HAZ_STALL_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of PC stall cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= 32'd0;
      end else if (o_pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
